// File: rtl/camera_pkg.sv
// Shared types and constants for the capture sequencer: phase enum,
// exposure clamp limits, and the fixed readout control pattern.
package camera_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ERASE,
    S_EXPOSE,
    S_READOUT
  } state_t;

  localparam logic [4:0] EXP_MIN   = 5'd2;
  localparam logic [4:0] EXP_MAX   = 5'd30;
  localparam logic [4:0] EXP_RESET = 5'd15;

  localparam int READOUT_STEPS = 8;

  // Pixel-array read controls for one readout step (NRE lines active low)
  typedef struct packed {
    logic nre_1;
    logic nre_2;
    logic adc;
  } readout_t;

  // Keep the exposure inside the range the sensor supports
  function automatic logic [4:0] clamp_exp(input logic [4:0] t);
    if (t < EXP_MIN)
      return EXP_MIN;
    else if (t > EXP_MAX)
      return EXP_MAX;
    else
      return t;
  endfunction

  // Row 1 is read in steps 0-2, row 2 in steps 4-6, ADC strobes mid-row
  function automatic readout_t readout_pattern(input logic [2:0] step);
    readout_t p;
    p.nre_1 = 1'b1;
    p.nre_2 = 1'b1;
    p.adc   = 1'b0;
    case (step)
      3'd0, 3'd2: p.nre_1 = 1'b0;
      3'd1: begin
        p.nre_1 = 1'b0;
        p.adc   = 1'b1;
      end
      3'd4, 3'd6: p.nre_2 = 1'b0;
      3'd5: begin
        p.nre_2 = 1'b0;
        p.adc   = 1'b1;
      end
      default: ;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: one-cycle Tick every TICK_DIV clocks while Clear
// is low. Clear (or Reset low) restarts the count so the first tick after
// release arrives exactly TICK_DIV cycles later.
module ms_tick_gen #(
  parameter int TICK_DIV = 1
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Clear,
  output logic Tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  // Free-running modulo-TICK_DIV counter, held at zero while cleared
  always_ff @(posedge Clk) begin
    if (!Reset || Clear)
      count <= '0;
    else if (count == LAST)
      count <= '0;
    else
      count <= count + 1'b1;
  end

  assign Tick = !Clear && (count == LAST);

endmodule

// File: rtl/capture_sequencer.sv
// Image capture sequencer: Erase -> Expose -> Readout around the latched
// exposure time, plus gating of exposure register up/down requests.
// Build option: define ERASE_PHASE_EN to include the Erase phase; when it
// is undefined the capture goes straight from IDLE to EXPOSE and Erase=0.
module capture_sequencer
  import camera_pkg::*;
#(
  parameter int TICK_DIV     = 1,
  parameter int ERASE_CYCLES = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Init,
  input  logic       Abort,
  input  logic [4:0] Exp_Time,
  input  logic       Exp_Increase,
  input  logic       Exp_Decrease,
  output logic       Exp_Increase_Out,
  output logic       Exp_Decrease_Out,
  output logic       Erase,
  output logic       Expose,
  output logic       NRE_1,
  output logic       NRE_2,
  output logic       ADC,
  output logic       Busy,
  output logic       Done
);

  if (TICK_DIV < 1 || ERASE_CYCLES < 1) begin : g_param_check
    $error("capture_sequencer: TICK_DIV and ERASE_CYCLES must be >= 1");
  end

  localparam logic [2:0] LAST_STEP = 3'(READOUT_STEPS - 1);

  state_t     state;
  logic [4:0] latched_time;
  logic [4:0] ms_cnt;
  logic [2:0] step;
  logic       ms_clear;
  logic       ms_tick;

`ifdef ERASE_PHASE_EN
  localparam int EW = (ERASE_CYCLES > 1) ? $clog2(ERASE_CYCLES) : 1;
  localparam logic [EW-1:0] LAST_ERASE = EW'(ERASE_CYCLES - 1);
  logic [EW-1:0] erase_cnt;
`else
  assign Erase = 1'b0;
`endif

  // The prescaler only runs during exposure so each phase starts aligned
  assign ms_clear = (state != S_EXPOSE);

  ms_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_ms_tick (
    .Clk  (Clk),
    .Reset(Reset),
    .Clear(ms_clear),
    .Tick (ms_tick)
  );

  // Capture FSM with registered phase outputs set on the entering edge
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state        <= S_IDLE;
      latched_time <= EXP_RESET;
      ms_cnt       <= '0;
      step         <= '0;
`ifdef ERASE_PHASE_EN
      erase_cnt    <= '0;
      Erase        <= 1'b0;
`endif
      Expose       <= 1'b0;
      NRE_1        <= 1'b1;
      NRE_2        <= 1'b1;
      ADC          <= 1'b0;
      Done         <= 1'b0;
    end else begin
      Done <= 1'b0;
      if (state != S_IDLE && Abort) begin
        state  <= S_IDLE;
        ms_cnt <= '0;
        step   <= '0;
`ifdef ERASE_PHASE_EN
        erase_cnt <= '0;
        Erase     <= 1'b0;
`endif
        Expose <= 1'b0;
        NRE_1  <= 1'b1;
        NRE_2  <= 1'b1;
        ADC    <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (Init) begin
              latched_time <= clamp_exp(Exp_Time);
              ms_cnt       <= '0;
              step         <= '0;
`ifdef ERASE_PHASE_EN
              state        <= S_ERASE;
              erase_cnt    <= '0;
              Erase        <= 1'b1;
`else
              state        <= S_EXPOSE;
              Expose       <= 1'b1;
`endif
            end
          end
`ifdef ERASE_PHASE_EN
          S_ERASE: begin
            if (erase_cnt == LAST_ERASE) begin
              state     <= S_EXPOSE;
              erase_cnt <= '0;
              Erase     <= 1'b0;
              Expose    <= 1'b1;
            end else begin
              erase_cnt <= erase_cnt + 1'b1;
            end
          end
`endif
          S_EXPOSE: begin
            if (ms_tick) begin
              if (ms_cnt == latched_time - 5'd1) begin
                state  <= S_READOUT;
                ms_cnt <= '0;
                Expose <= 1'b0;
                step   <= '0;
                {NRE_1, NRE_2, ADC} <= readout_pattern(3'd0);
              end else begin
                ms_cnt <= ms_cnt + 5'd1;
              end
            end
          end
          S_READOUT: begin
            if (step == LAST_STEP) begin
              state <= S_IDLE;
              step  <= '0;
              NRE_1 <= 1'b1;
              NRE_2 <= 1'b1;
              ADC   <= 1'b0;
              Done  <= 1'b1;
            end else begin
              step <= step + 3'd1;
              {NRE_1, NRE_2, ADC} <= readout_pattern(step + 3'd1);
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Exposure setting may only move while idle with no capture starting
  assign Exp_Increase_Out = Exp_Increase & (state == S_IDLE) & ~Init;
  assign Exp_Decrease_Out = Exp_Decrease & (state == S_IDLE) & ~Init & ~Exp_Increase;

  assign Busy = (state != S_IDLE);

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer. Expected outputs come from a
// phase timeline: label k is the cycle following the k-th edge after the
// Init edge (k=1 is the cycle right after Init is sampled).
module tb_capture_sequencer;

  localparam int TICK  = 2;
  localparam int ERASE = 2;
`ifdef ERASE_PHASE_EN
  localparam int E_LEN = ERASE;
`else
  localparam int E_LEN = 0;
`endif

  // {Erase, Expose, NRE_1, NRE_2, ADC, Busy, Done}
  localparam logic [6:0] IDLE_VEC   = 7'b0011000;
  localparam logic [6:0] DONE_VEC   = 7'b0011001;
  localparam logic [6:0] ERASE_VEC  = 7'b1011010;
  localparam logic [6:0] EXPOSE_VEC = 7'b0111010;

  logic       Clk;
  logic       Reset;
  logic       Init;
  logic       Abort;
  logic [4:0] Exp_Time;
  logic       Exp_Increase;
  logic       Exp_Decrease;
  logic       Exp_Increase_Out;
  logic       Exp_Decrease_Out;
  logic       Erase;
  logic       Expose;
  logic       NRE_1;
  logic       NRE_2;
  logic       ADC;
  logic       Busy;
  logic       Done;

  int checks = 0;
  int errors = 0;

  capture_sequencer #(
    .TICK_DIV    (TICK),
    .ERASE_CYCLES(ERASE)
  ) dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .Init            (Init),
    .Abort           (Abort),
    .Exp_Time        (Exp_Time),
    .Exp_Increase    (Exp_Increase),
    .Exp_Decrease    (Exp_Decrease),
    .Exp_Increase_Out(Exp_Increase_Out),
    .Exp_Decrease_Out(Exp_Decrease_Out),
    .Erase           (Erase),
    .Expose          (Expose),
    .NRE_1           (NRE_1),
    .NRE_2           (NRE_2),
    .ADC             (ADC),
    .Busy            (Busy),
    .Done            (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Single comparison point: counts and reports every check
  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [6:0] out_vec();
    return {Erase, Expose, NRE_1, NRE_2, ADC, Busy, Done};
  endfunction

  // Timeline of a full capture with exposure lat ms
  function automatic logic [6:0] exp_vec(input int k, input int lat);
    int x;
    int l;
    int s;
    x = lat * TICK;
    l = E_LEN + x + 9;
    if (k < 1 || k > l) return IDLE_VEC;
    if (k == l) return DONE_VEC;
    if (k <= E_LEN) return ERASE_VEC;
    if (k <= E_LEN + x) return EXPOSE_VEC;
    s = k - E_LEN - x - 1;
    return {2'b00, !(s <= 2), !(s >= 4 && s <= 6), (s == 1 || s == 5), 1'b1, 1'b0};
  endfunction

  // One capture: t is the register value, lat the hand-clamped exposure.
  // abort_at / reset_at / chg_at are labels (0 = unused).
  task automatic run_capture(input string name, input logic [4:0] t, input int lat,
                             input int abort_at, input int reset_at, input int chg_at,
                             input logic [4:0] chg_val, input bit hold, input bit abort_with_init);
    int l;
    logic [6:0] expected;
    l = E_LEN + lat * TICK + 9;
    @(negedge Clk);
    Exp_Time = t;
    Init     = 1'b1;
    Abort    = abort_with_init;
    @(posedge Clk);
    for (int k = 1; k <= l + 2; k++) begin
      @(negedge Clk);
      if (k == 1 && !hold) Init = 1'b0;
      if (k == 1 && abort_with_init) Abort = 1'b0;
      if ((abort_at > 0 && k > abort_at) || (reset_at > 0 && k > reset_at))
        expected = IDLE_VEC;
      else if (hold && k > l)
        expected = exp_vec(k - l, lat);
      else
        expected = exp_vec(k, lat);
      check_output($sformatf("%s k=%0d", name, k), 32'(out_vec()), 32'(expected));
      if (k == 2) begin
        Exp_Increase = 1'b1;
        Exp_Decrease = 1'b1;
        #1;
        check_output($sformatf("%s busy_gate", name),
                     {30'd0, Exp_Increase_Out, Exp_Decrease_Out}, 32'd0);
        Exp_Increase = 1'b0;
        Exp_Decrease = 1'b0;
      end
      if (k == chg_at) Exp_Time = chg_val;
      if (k == abort_at) Abort = 1'b1;
      if (k == abort_at + 1) Abort = 1'b0;
      if (k == reset_at) Reset = 1'b0;
      if (k == reset_at + 3) Reset = 1'b1;
      if (hold && k == l + 1) Init = 1'b0;
    end
    Abort = 1'b0;
    Reset = 1'b1;
    if (hold) begin
      Abort = 1'b1;
      @(negedge Clk);
      Abort = 1'b0;
      check_output($sformatf("%s hold_abort", name), 32'(out_vec()), 32'(IDLE_VEC));
    end
  endtask

  // Combinational gating while idle: {inc, dec, init} -> {inc_out, dec_out}
  task automatic applyStimulus_gate(input logic [2:0] vin, input logic [1:0] vexp);
    @(negedge Clk);
    {Exp_Increase, Exp_Decrease, Init} = vin;
    #1;
    check_output($sformatf("idle_gate %b", vin),
                 {30'd0, Exp_Increase_Out, Exp_Decrease_Out}, {30'd0, vexp});
    {Exp_Increase, Exp_Decrease, Init} = 3'b000;
  endtask

  initial begin
    Reset        = 1'b0;
    Init         = 1'b0;
    Abort        = 1'b0;
    Exp_Time     = 5'd15;
    Exp_Increase = 1'b0;
    Exp_Decrease = 1'b0;

    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check_output("reset_state", 32'(out_vec()), 32'(IDLE_VEC));
    Reset = 1'b1;

    applyStimulus_gate(3'b000, 2'b00);
    applyStimulus_gate(3'b100, 2'b10);
    applyStimulus_gate(3'b010, 2'b01);
    applyStimulus_gate(3'b110, 2'b10);
    applyStimulus_gate(3'b101, 2'b00);
    applyStimulus_gate(3'b011, 2'b00);

    // Abort in idle is ignored and does not block the start
    @(negedge Clk);
    Abort = 1'b1;
    @(negedge Clk);
    check_output("idle_abort", 32'(out_vec()), 32'(IDLE_VEC));
    Abort = 1'b0;

    run_capture("nominal15", 5'd15, 15, 0, 0, 0, 5'd0, 1'b0, 1'b0);
    run_capture("clamp0",    5'd0,  2,  0, 0, 0, 5'd0, 1'b0, 1'b0);
    run_capture("clamp31",   5'd31, 30, 0, 0, 0, 5'd0, 1'b0, 1'b0);
    run_capture("clamp1",    5'd1,  2,  0, 0, 0, 5'd0, 1'b0, 1'b0);
    run_capture("exp_chg",   5'd15, 15, 0, 0, E_LEN + 3, 5'd5, 1'b0, 1'b0);
    run_capture("reset_mid", 5'd15, 15, 0, E_LEN + 4, 0, 5'd0, 1'b0, 1'b0);
    run_capture("abort_ro2", 5'd15, 15, E_LEN + 15 * TICK + 3, 0, 0, 5'd0, 1'b0, 1'b0);
    run_capture("after_abort", 5'd5, 5, 0, 0, 0, 5'd0, 1'b0, 1'b0);
    run_capture("abort_init", 5'd4, 4, 0, 0, 0, 5'd0, 1'b0, 1'b1);
    run_capture("held_init", 5'd3, 3, 0, 0, 0, 5'd0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/capture_sequencer.md
# capture_sequencer

Sequences one image capture around the exposure-time register: on a start request it runs Erase, Expose and Readout phases, driving the pixel-array control lines and the ADC strobe. Exposure length comes from the 5-bit ms exposure register. The block also gates the register's increase/decrease requests so the exposure setting cannot change during a capture. It sits between the camera's button/control logic and the sensor array/ADC.

## Interface
- TICK_DIV, 1, Clk cycles per 1 ms exposure unit (≥1)
- ERASE_CYCLES, 2, Clk cycles the Erase phase lasts (≥1)
- Clk  in  1  system clock; all logic on rising edge
- Reset  in  1  synchronous, active-low reset
- Init  in  1  capture start request, level-sampled
- Abort  in  1  cancel the running capture
- Exp_Time  in  5  exposure time in ms from the exposure register
- Exp_Increase  in  1  increase request from user controls
- Exp_Decrease  in  1  decrease request from user controls
- Exp_Increase_Out  out  1  gated increase to the exposure register
- Exp_Decrease_Out  out  1  gated decrease to the exposure register
- Erase  out  1  pixel erase, active high
- Expose  out  1  pixel integrate, active high
- NRE_1  out  1  row-1 read enable, active low
- NRE_2  out  1  row-2 read enable, active low
- ADC  out  1  ADC convert strobe, active high
- Busy  out  1  capture in progress
- Done  out  1  one-cycle capture-complete pulse

## Operation
- States: IDLE, ERASE, EXPOSE, READOUT. Reset (Reset=0 at an edge) forces IDLE from any state. Reset values: Erase=0, Expose=0, NRE_1=1, NRE_2=1, ADC=0, Busy=0, Done=0. All counters are cleared.
- IDLE: Init=1 → ERASE. On the same edge, latch Exp_Time clamped to 2..30. Latched 0 or 1 becomes 2; 31 becomes 30.
- ERASE: Erase=1 for ERASE_CYCLES cycles → EXPOSE.
- EXPOSE: Expose=1 for latched_time×TICK_DIV cycles → READOUT. An ms_tick prescaler counts TICK_DIV cycles. A 5-bit ms counter counts up to latched_time.
- READOUT: a fixed 8-step sequence, one cycle per step, with step counter 0..7:
  - step 0: NRE_1=0
  - step 1: NRE_1=0, ADC=1
  - step 2: NRE_1=0
  - step 3: all inactive
  - step 4: NRE_2=0
  - step 5: NRE_2=0, ADC=1
  - step 6: NRE_2=0
  - step 7: all inactive
  - After step 7 → IDLE with Done=1 for one cycle.
- Abort=1 in ERASE, EXPOSE or READOUT → IDLE on the next edge. Outputs return to reset values and no Done is issued. Abort in IDLE has no effect. If Abort and Init are both 1 in IDLE, the capture starts.
- Init while not IDLE is ignored; no queuing. Init held high after Done starts a new capture on the following edge.
- Gating (combinational):
  - Exp_Increase_Out = Exp_Increase & (state==IDLE) & !Init.
  - Exp_Decrease_Out = Exp_Decrease & (state==IDLE) & !Init & !Exp_Increase. Increase wins when both are requested.
- Busy = (state != IDLE).

## Timing
- All phase outputs are registered and change on the edge that enters a phase or step.
- Init sampled at edge T: Erase=1 from T+1 through T+ERASE_CYCLES.
- Expose=1 for exactly latched_time×TICK_DIV cycles.
- Readout takes 8 cycles. Done is asserted on the first IDLE cycle.
- Total latency from the Init edge to Done = ERASE_CYCLES + latched_time×TICK_DIV + 8 + 1 cycles. With defaults and Exp_Time=15 this is 26 cycles.
- A change to Exp_Time during a capture has no effect; only the value latched at start is used.

## Configuration
- ERASE_PHASE_EN:
  - Defined: behaviour as above.
  - Undefined: the ERASE state is removed. IDLE+Init → EXPOSE directly, Erase is tied to 0, ERASE_CYCLES is ignored, and latency drops by ERASE_CYCLES.

## Structure
- Shared package camera_pkg holds:
  - the state enum (S_IDLE, S_ERASE, S_EXPOSE, S_READOUT);
  - EXP_MIN=2, EXP_MAX=30, EXP_RESET=15;
  - READOUT_STEPS=8.
- One sub-module, ms_tick_gen: TICK_DIV prescaler with synchronous active-low reset and a clear input; emits a one-cycle tick every TICK_DIV cycles.

## Test plan
- Reset held low 3 cycles mid-EXPOSE → next edge: all outputs at reset values, Busy=0, no Done.
- TICK_DIV=1, ERASE_CYCLES=2, Exp_Time=15, Init pulse → Erase high for 2 cycles, Expose for 15, NRE/ADC pattern over 8 cycles, Done at Init+26.
- Exp_Time=0, then 31 → Expose lasts 2, then 30 cycles. Exp_Time changed from 15 to 5 during Expose → still 15.
- Abort during READOUT step 2 → next cycle IDLE, NRE_1=1, no Done. A new Init then runs a full capture.
- Exp_Increase=1 during Busy → Exp_Increase_Out=0. Both requests in IDLE → only Exp_Increase_Out=1.
- ERASE_PHASE_EN undefined, Exp_Time=4, TICK_DIV=3 → Expose from Init+1 for 12 cycles, Erase never high, Done at Init+21.
